// File: rtl/lms_ctr_gpio_seq_pkg.sv
// lms_ctr_gpio_seq_pkg
//   Shared definitions for the LMS control GPIO sequencer:
//   - request op encodings carried on reqN_op
//   - GPIO PIO register addresses (data, set, clear)
//   - sequencer state encoding
package lms_ctr_gpio_seq_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_PULSE = 2'b11;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR1  = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR2  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/lms_ctr_rr_arb2.sv
// lms_ctr_rr_arb2
//   Two-requester round-robin arbiter with a registered priority pointer.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset (pointer -> req0)
//     en           : grants are only issued while en is high
//     req0, req1   : request lines
//     gnt0, gnt1   : combinational one-hot grant (at most one high)
module lms_ctr_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr_q = 0: req0 has priority, ptr_q = 1: req1 has priority
  logic ptr_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && (!ptr_q || !req1)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // After every grant the pointer hands priority to the other requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (gnt0) begin
      ptr_q <= 1'b1;
    end else if (gnt1) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/lms_ctr_gpio_seq.sv
// lms_ctr_gpio_seq
//   Avalon-MM master sequencer and 2-way round-robin arbiter in front of the
//   4-bit LMS control GPIO (data / set / clear registers). Requests (write,
//   set, clear, timed pulse) from the CPU (req0) and the bring-up logic
//   (req1) are serialised into single-cycle GPIO writes; a shadow copy of the
//   GPIO output register is kept.
//
//   Optional feature macro: LMS_CTR_GPIO_SEQ_PULSE_EN
//     defined   : pulse op = clear write, wait max(len,1) cycles, set write
//     undefined : pulse op is accepted and completes with no bus write;
//                 the len inputs are unused
//
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     reqN_valid/op/mask/len      request N (held until reqN_ready)
//     reqN_ready                  one-cycle accept strobe
//     gpio_address/chipselect/write_n/writedata   Avalon-MM write master
//     shadow                      mirror of the GPIO output register
//     busy                        high whenever not idle
//     done, done_id               completion pulse and requester id
module lms_ctr_gpio_seq
  import lms_ctr_gpio_seq_pkg::*;
#(
  parameter int         PULSE_W = 16,
  parameter logic [3:0] RST_VAL = 4'h3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [1:0]         req0_op,
  input  logic [3:0]         req0_mask,
  input  logic [PULSE_W-1:0] req0_len,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [1:0]         req1_op,
  input  logic [3:0]         req1_mask,
  input  logic [PULSE_W-1:0] req1_len,
  output logic               req1_ready,
  output logic [2:0]         gpio_address,
  output logic               gpio_chipselect,
  output logic               gpio_write_n,
  output logic [31:0]        gpio_writedata,
  output logic [3:0]         shadow,
  output logic               busy,
  output logic               done,
  output logic               done_id
);

  // GPIO register semantics for a write of val to addr.
  function automatic logic [3:0] gpio_apply(input logic [3:0] cur,
                                            input logic [2:0] addr,
                                            input logic [3:0] val);
    logic [3:0] res;
    res = cur;
    case (addr)
      ADDR_DATA: res = val;
      ADDR_SET:  res = cur | val;
      ADDR_CLR:  res = cur & ~val;
      default:   res = cur;
    endcase
    return res;
  endfunction

  state_t     state_q, state_d;
  logic       gnt0, gnt1, gnt_any;
  logic [1:0] sel_op;
  logic [3:0] sel_mask;

  // Latched request; data only, so no reset is needed.
  logic [1:0] op_q;
  logic [3:0] mask_q;
  logic       id_q;
  logic [3:0] shadow_q;
  logic       wr_en;

  lms_ctr_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_IDLE),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign gnt_any    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign sel_op     = gnt1 ? req1_op   : req0_op;
  assign sel_mask   = gnt1 ? req1_mask : req0_mask;

  always_ff @(posedge clk) begin
    if (gnt_any) begin
      op_q   <= sel_op;
      mask_q <= sel_mask;
      id_q   <= gnt1;
    end
  end

`ifdef LMS_CTR_GPIO_SEQ_PULSE_EN
  logic [PULSE_W-1:0] len_q;
  logic [PULSE_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (gnt_any) begin
      len_q <= gnt1 ? req1_len : req0_len;
    end
  end

  // Loaded once while leaving WR1 so WAIT lasts exactly max(len,1) cycles;
  // a length of 0 is promoted to 1 and all-ones never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_WR1 && op_q == OP_PULSE) begin
      cnt_q <= (len_q == '0) ? PULSE_W'(1) : len_q;
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q - PULSE_W'(1);
    end
  end
`else
  logic unused_len;
  assign unused_len = ^{req0_len, req1_len};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
`ifdef LMS_CTR_GPIO_SEQ_PULSE_EN
          state_d = ST_WR1;
`else
          state_d = (sel_op == OP_PULSE) ? ST_FIN : ST_WR1;
`endif
        end
      end
      ST_WR1: begin
`ifdef LMS_CTR_GPIO_SEQ_PULSE_EN
        state_d = (op_q == OP_PULSE) ? ST_WAIT : ST_FIN;
`else
        state_d = ST_FIN;
`endif
      end
`ifdef LMS_CTR_GPIO_SEQ_PULSE_EN
      ST_WAIT: begin
        if (cnt_q == PULSE_W'(1)) begin
          state_d = ST_WR2;
        end
      end
      ST_WR2:  state_d = ST_FIN;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus master: strobes only in WR1 / WR2, idle values everywhere else.
  always_comb begin
    wr_en           = 1'b0;
    gpio_address    = ADDR_DATA;
    gpio_writedata  = 32'd0;
    case (state_q)
      ST_WR1: begin
        wr_en          = 1'b1;
        gpio_writedata = {28'd0, mask_q};
        case (op_q)
          OP_WRITE: gpio_address = ADDR_DATA;
          OP_SET:   gpio_address = ADDR_SET;
          default:  gpio_address = ADDR_CLR;
        endcase
      end
`ifdef LMS_CTR_GPIO_SEQ_PULSE_EN
      ST_WR2: begin
        wr_en          = 1'b1;
        gpio_address   = ADDR_SET;
        gpio_writedata = {28'd0, mask_q};
      end
`endif
      default: ;
    endcase
  end

  assign gpio_chipselect = wr_en;
  assign gpio_write_n    = ~wr_en;

  // Shadow follows the GPIO register, which shares this reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= RST_VAL;
    end else if (wr_en) begin
      shadow_q <= gpio_apply(shadow_q, gpio_address, mask_q);
    end
  end

  assign shadow  = shadow_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_FIN);
  assign done_id = (state_q == ST_FIN) & id_q;

endmodule

// File: tb/tb_lms_ctr_gpio_seq.sv
// tb_lms_ctr_gpio_seq
//   Directed bench for lms_ctr_gpio_seq. Inputs are driven on the falling
//   edge, outputs checked 1 time unit later, away from the rising edge.
//   The pulse group is selected by LMS_CTR_GPIO_SEQ_PULSE_EN.
module tb_lms_ctr_gpio_seq;
  import lms_ctr_gpio_seq_pkg::*;

  localparam int PULSE_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req0_valid = 1'b0;
  logic [1:0]         req0_op = 2'b00;
  logic [3:0]         req0_mask = 4'h0;
  logic [PULSE_W-1:0] req0_len = '0;
  logic               req0_ready;
  logic               req1_valid = 1'b0;
  logic [1:0]         req1_op = 2'b00;
  logic [3:0]         req1_mask = 4'h0;
  logic [PULSE_W-1:0] req1_len = '0;
  logic               req1_ready;
  logic [2:0]         gpio_address;
  logic               gpio_chipselect;
  logic               gpio_write_n;
  logic [31:0]        gpio_writedata;
  logic [3:0]         shadow;
  logic               busy;
  logic               done;
  logic               done_id;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lms_ctr_gpio_seq #(.PULSE_W(PULSE_W), .RST_VAL(4'h3)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_op         (req0_op),
    .req0_mask       (req0_mask),
    .req0_len        (req0_len),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_op         (req1_op),
    .req1_mask       (req1_mask),
    .req1_len        (req1_len),
    .req1_ready      (req1_ready),
    .gpio_address    (gpio_address),
    .gpio_chipselect (gpio_chipselect),
    .gpio_write_n    (gpio_write_n),
    .gpio_writedata  (gpio_writedata),
    .shadow          (shadow),
    .busy            (busy),
    .done            (done),
    .done_id         (done_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_idle(input string tag);
    chk({tag, "_cs"},   gpio_chipselect, 1'b0);
    chk({tag, "_wn"},   gpio_write_n,    1'b1);
    chk({tag, "_addr"}, gpio_address,    3'd0);
    chk({tag, "_data"}, gpio_writedata,  32'd0);
  endtask

  task automatic bus_wr(input string tag, input logic [2:0] a, input logic [3:0] d);
    chk({tag, "_cs"},   gpio_chipselect, 1'b1);
    chk({tag, "_wn"},   gpio_write_n,    1'b0);
    chk({tag, "_addr"}, gpio_address,    a);
    chk({tag, "_data"}, gpio_writedata,  {28'd0, d});
  endtask

  // Holds reset for two rising edges, checks the reset state, releases.
  task automatic do_reset(input string tag);
    tick();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    #1;
    chk({tag, "_shadow"},  shadow,     4'h3);
    chk({tag, "_busy"},    busy,       1'b0);
    chk({tag, "_done"},    done,       1'b0);
    chk({tag, "_done_id"}, done_id,    1'b0);
    chk({tag, "_rdy0"},    req0_ready, 1'b0);
    chk({tag, "_rdy1"},    req1_ready, 1'b0);
    bus_idle(tag);
    reset = 1'b0;
  endtask

  initial begin
    // ---- reset, then req0 set 4'h4 ----
    do_reset("rst0");
    tick(); req0_valid = 1'b1; req0_op = OP_SET; req0_mask = 4'h4; #1;
    chk("a_rdy0", req0_ready, 1'b1);
    chk("a_rdy1", req1_ready, 1'b0);
    chk("a_busy_t0", busy, 1'b0);
    bus_idle("a_t0");
    tick(); req0_valid = 1'b0; #1;
    bus_wr("a_t1", ADDR_SET, 4'h4);
    chk("a_shadow_t1", shadow, 4'h3);
    chk("a_busy_t1", busy, 1'b1);
    chk("a_done_t1", done, 1'b0);
    tick(); #1;
    chk("a_done_t2", done, 1'b1);
    chk("a_id_t2", done_id, 1'b0);
    chk("a_shadow_t2", shadow, 4'h7);
    bus_idle("a_t2");
    tick(); #1;
    chk("a_busy_t3", busy, 1'b0);
    chk("a_done_t3", done, 1'b0);

    // ---- simultaneous requests after reset: req0 clear 1, req1 write 8 ----
    do_reset("rst1");
    tick();
    req0_valid = 1'b1; req0_op = OP_CLR;   req0_mask = 4'h1;
    req1_valid = 1'b1; req1_op = OP_WRITE; req1_mask = 4'h8; #1;
    chk("b_rdy0_t0", req0_ready, 1'b1);
    chk("b_rdy1_t0", req1_ready, 1'b0);
    tick(); req0_valid = 1'b0; #1;
    bus_wr("b_t1", ADDR_CLR, 4'h1);
    chk("b_rdy1_t1", req1_ready, 1'b0);
    tick(); #1;
    chk("b_done_t2", done, 1'b1);
    chk("b_id_t2", done_id, 1'b0);
    chk("b_shadow_t2", shadow, 4'h2);
    chk("b_rdy1_t2", req1_ready, 1'b0);
    tick(); #1;
    chk("b_rdy1_t3", req1_ready, 1'b1);
    chk("b_busy_t3", busy, 1'b0);
    tick(); req1_valid = 1'b0; #1;
    bus_wr("b_t4", ADDR_DATA, 4'h8);
    tick(); #1;
    chk("b_done_t5", done, 1'b1);
    chk("b_id_t5", done_id, 1'b1);
    chk("b_shadow_t5", shadow, 4'h8);

    // ---- both held valid: rotation, mask 0 still writes ----
    tick();
    req0_valid = 1'b1; req0_op = OP_SET; req0_mask = 4'h0;
    req1_valid = 1'b1; req1_op = OP_SET; req1_mask = 4'h0; #1;
    chk("c_rdy0_t0", req0_ready, 1'b1);
    chk("c_rdy1_t0", req1_ready, 1'b0);
    tick(); #1;
    bus_wr("c_t1", ADDR_SET, 4'h0);
    tick(); #1;
    chk("c_done_t2", done, 1'b1);
    chk("c_shadow_t2", shadow, 4'h8);
    tick(); #1;
    chk("c_rdy0_t3", req0_ready, 1'b0);
    chk("c_rdy1_t3", req1_ready, 1'b1);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    bus_wr("c_t4", ADDR_SET, 4'h0);
    tick(); #1;
    chk("c_done_t5", done, 1'b1);
    chk("c_id_t5", done_id, 1'b1);

    // ---- reset during the bus write cycle aborts the request ----
    do_reset("rst2");
    tick(); req0_valid = 1'b1; req0_op = OP_CLR; req0_mask = 4'h3; #1;
    chk("d_rdy0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0; #1;
    bus_wr("d_t1", ADDR_CLR, 4'h3);
    reset = 1'b1;
    tick(); #1;
    chk("d_busy", busy, 1'b0);
    chk("d_shadow", shadow, 4'h3);
    chk("d_done", done, 1'b0);
    bus_idle("d_t2");
    reset = 1'b0;
    tick(); #1;
    chk("d_done_after", done, 1'b0);
    chk("d_busy_after", busy, 1'b0);

`ifdef LMS_CTR_GPIO_SEQ_PULSE_EN
    // ---- pulse mask 1, len 5 ----
    do_reset("rst3");
    tick(); req0_valid = 1'b1; req0_op = OP_PULSE; req0_mask = 4'h1; req0_len = 16'd5; #1;
    chk("p_rdy0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0; #1;
    bus_wr("p_t1", ADDR_CLR, 4'h1);
    for (int i = 2; i <= 6; i++) begin
      tick(); #1;
      chk($sformatf("p_shadow_t%0d", i), shadow, 4'h2);
      chk($sformatf("p_cs_t%0d", i), gpio_chipselect, 1'b0);
      chk($sformatf("p_done_t%0d", i), done, 1'b0);
    end
    tick(); #1;
    bus_wr("p_t7", ADDR_SET, 4'h1);
    chk("p_shadow_t7", shadow, 4'h2);
    tick(); #1;
    chk("p_done_t8", done, 1'b1);
    chk("p_shadow_t8", shadow, 4'h3);

    // ---- pulse len 0 behaves as len 1 ----
    tick(); req1_valid = 1'b1; req1_op = OP_PULSE; req1_mask = 4'h2; req1_len = 16'd0; #1;
    chk("q_rdy1", req1_ready, 1'b1);
    tick(); req1_valid = 1'b0; #1;
    bus_wr("q_t1", ADDR_CLR, 4'h2);
    tick(); #1;
    chk("q_cs_t2", gpio_chipselect, 1'b0);
    chk("q_shadow_t2", shadow, 4'h1);
    tick(); #1;
    bus_wr("q_t3", ADDR_SET, 4'h2);
    tick(); #1;
    chk("q_done_t4", done, 1'b1);
    chk("q_id_t4", done_id, 1'b1);
    chk("q_shadow_t4", shadow, 4'h3);

    // ---- reset during WAIT ----
    do_reset("rst4");
    tick(); req0_valid = 1'b1; req0_op = OP_PULSE; req0_mask = 4'h1; req0_len = 16'd5; #1;
    tick(); req0_valid = 1'b0;
    tick(); tick(); #1;
    chk("w_busy_wait", busy, 1'b1);
    chk("w_shadow_wait", shadow, 4'h2);
    reset = 1'b1;
    tick(); #1;
    chk("w_busy", busy, 1'b0);
    chk("w_shadow", shadow, 4'h3);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk($sformatf("w_cs_%0d", i), gpio_chipselect, 1'b0);
      chk($sformatf("w_done_%0d", i), done, 1'b0);
    end
`else
    // ---- pulse op without the feature: straight to done, no strobe ----
    do_reset("rst3");
    tick(); req0_valid = 1'b1; req0_op = OP_PULSE; req0_mask = 4'h1; req0_len = 16'd5; #1;
    chk("n_rdy0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0; #1;
    chk("n_done_t1", done, 1'b1);
    chk("n_id_t1", done_id, 1'b0);
    chk("n_shadow_t1", shadow, 4'h3);
    bus_idle("n_t1");
    tick(); #1;
    chk("n_busy_t2", busy, 1'b0);
    chk("n_done_t2", done, 1'b0);
    chk("n_shadow_t2", shadow, 4'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
